inst_fetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle ARM-subset core (decode/execute).
- Owns the fetch PC and issues word reads to code memory over a valid/ready request / in-order response interface.
- Buffers returned instructions with their PCs in a small prefetch queue and presents them to the core over a valid/ready handshake.
- Taken branches from the core arrive as a redirect that flushes the queue and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/inst_fetch_queue_if.sv | 34 +++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_queue.sv | 120 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: queue entry
// layout, instruction size, PC alignment mask and default reset PC.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int INST_BYTES       = 4;

  localparam logic [FETCH_ADDR_WIDTH-1:0] PC_ALIGN_MASK  = ~FETCH_ADDR_WIDTH'(INST_BYTES - 1);
  localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [31:0]                 inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundles the memory request/response, redirect and core-side instruction
// handshakes of the fetch stage; master is the fetch unit, slave its environment.
interface inst_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [31:0]           mem_rsp_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [31:0]           inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [CW-1:0]         dbg_count;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, dbg_count,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, dbg_count,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush used for both the prefetch queue and
// the PC-tag FIFO; a push while full is honoured only alongside a pop.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  T              i_data,
  output T              o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop) && !i_flush;

  always_ff @(posedge clk) begin
    if (w_doPush && !nreset) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap explicitly so a non-power-of-two depth still works.
  always_ff @(posedge clk) begin
    if (nreset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word reads
// and queues returned instructions for the core. Option: FETCH_BYPASS_EN.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    QUEUE_DEPTH     = 4,
  parameter int                    ADDR_WIDTH      = FETCH_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = FETCH_RESET_PC,
  parameter int                    MAX_OUTSTANDING = 4
) (
  input logic              clk,
  input logic              nreset,
  inst_fetch_queue_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [ADDR_WIDTH-1:0] r_fetchPc;
  logic [OW-1:0]         r_discard;
  logic [OW-1:0]         w_outstanding;
  logic [ADDR_WIDTH-1:0] w_rspPc;
  logic [CW-1:0]         w_qCount;
  fetch_entry_t          w_qIn;
  fetch_entry_t          w_qHead;
  logic                  w_qEmpty, w_qFull, w_tagEmpty, w_tagFull;
  logic                  w_reqFire, w_rspFire, w_rspKeep, w_qPush, w_qPop, w_bypass;

  // Responses with no tag outstanding are leftovers from before a reset.
  assign w_rspFire = bus.mem_rsp_valid && !w_tagEmpty;
  assign w_rspKeep = w_rspFire && (r_discard == '0) && !bus.redirect_valid;

  assign bus.mem_req_valid = !nreset && !bus.redirect_valid
                          && ((int'(w_qCount) + int'(w_outstanding)) < QUEUE_DEPTH)
                          && (int'(w_outstanding) < MAX_OUTSTANDING);
  assign bus.mem_req_addr  = r_fetchPc;
  assign bus.dbg_count     = w_qCount;
  assign w_reqFire         = bus.mem_req_valid && bus.mem_req_ready;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_rspKeep && w_qEmpty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_qPush = w_rspKeep && !(w_bypass && bus.inst_ready);
  assign w_qPop  = !w_qEmpty && bus.inst_ready && !bus.redirect_valid;
  assign w_qIn   = '{pc: w_rspPc, inst: bus.mem_rsp_data};

  always_comb begin
    bus.inst_valid = 1'b0;
    bus.inst_data  = '0;
    bus.inst_pc    = '0;
    if (!w_qEmpty) begin
      bus.inst_valid = 1'b1;
      bus.inst_data  = w_qHead.inst;
      bus.inst_pc    = w_qHead.pc;
    end else if (w_bypass) begin
      bus.inst_valid = 1'b1;
      bus.inst_data  = bus.mem_rsp_data;
      bus.inst_pc    = w_rspPc;
    end
  end

  // A redirect drops everything still in flight by counting it into discard.
  always_ff @(posedge clk) begin
    if (nreset) begin
      r_fetchPc <= RESET_PC;
      r_discard <= '0;
    end else if (bus.redirect_valid) begin
      r_fetchPc <= bus.redirect_pc & PC_ALIGN_MASK;
      r_discard <= w_outstanding - OW'(w_rspFire);
    end else begin
      if (w_reqFire) begin
        r_fetchPc <= r_fetchPc + ADDR_WIDTH'(INST_BYTES);
      end
      if (w_rspFire && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_qPush),
    .i_pop   (w_qPop),
    .i_flush (bus.redirect_valid),
    .i_data  (w_qIn),
    .o_data  (w_qHead),
    .o_count (w_qCount),
    .o_full  (w_qFull),
    .o_empty (w_qEmpty)
  );

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (logic [ADDR_WIDTH-1:0])
  ) u_pcTags (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_reqFire),
    .i_pop   (w_rspFire),
    .i_flush (1'b0),
    .i_data  (r_fetchPc),
    .o_data  (w_rspPc),
    .o_count (w_outstanding),
    .o_full  (w_tagFull),
    .o_empty (w_tagEmpty)
  );

  queueNoOverflow: assert property (@(posedge clk) disable iff (nreset)
    !(w_qPush && w_qFull && !w_qPop));
  tagNoOverflow: assert property (@(posedge clk) disable iff (nreset)
    !(w_reqFire && w_tagFull && !w_rspFire));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a fixed-latency memory model
// returning addr>>2 as instruction data.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4)) ifc ();

  inst_fetch_queue #(
    .QUEUE_DEPTH     (4),
    .ADDR_WIDTH      (32),
    .RESET_PC        (32'h0000_0000),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (ifc.master)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] reqLog[$];
  int          cyc = 0;
  int          memLat = 1;
  logic        memReady = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Memory model: response driven at the negedge, ready after #1, accept sampled after #2.
  initial begin
    ifc.mem_rsp_valid = 1'b0;
    ifc.mem_rsp_data  = '0;
    ifc.mem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      ifc.mem_rsp_valid = 1'b0;
      ifc.mem_rsp_data  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        ifc.mem_rsp_valid = 1'b1;
        ifc.mem_rsp_data  = pend[0].data;
        void'(pend.pop_front());
      end
      #1;
      ifc.mem_req_ready = memReady;
      #1;
      if (ifc.mem_req_valid && ifc.mem_req_ready) begin
        pend.push_back('{cyc + memLat, ifc.mem_req_addr >> 2});
        reqLog.push_back(ifc.mem_req_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset();
    nreset = 1'b1;
    memReady = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    ifc.inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    reqLog.delete();
    nreset = 1'b0;
    memReady = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    memReady = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    ifc.inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    checks++; if (ifc.mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%b exp=0", ifc.mem_req_valid); end
    checks++; if (ifc.inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_valid got=%b exp=0", ifc.inst_valid); end
    checks++; if (ifc.inst_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_data got=%h exp=0", ifc.inst_data); end
    checks++; if (ifc.inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_pc got=%h exp=0", ifc.inst_pc); end
    checks++; if (ifc.dbg_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", ifc.dbg_count); end
    @(negedge clk);
    reqLog.delete();
    nreset = 1'b0;
    #3;
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_first_req got valid=%b addr=%h exp valid=1 addr=0", ifc.mem_req_valid, ifc.mem_req_addr);
    end
  endtask

  task automatic test_in_order();
    int k = 0;
    memLat = 1;
    doReset();
    ifc.inst_ready = 1'b1;
    #3;
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (ifc.inst_valid) begin
        if (k == 0) begin
          checks++; if (i != 2) begin failures++; $display("[TB] FAIL inorder_latency got=%0d exp=2", i); end
        end
        checks++; if (ifc.inst_pc !== 32'(k * 4) || ifc.inst_data !== 32'(k)) begin
          failures++; $display("[TB] FAIL inorder_%0d got pc=%h data=%h exp pc=%h data=%h", k, ifc.inst_pc, ifc.inst_data, k * 4, k);
        end
        k++;
      end
      @(negedge clk); #3;
    end
    checks++; if (k != 4) begin failures++; $display("[TB] FAIL inorder_timeout got=%0d exp=4", k); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (reqLog.size() <= j || reqLog[j] !== 32'(j * 4)) begin
        failures++; $display("[TB] FAIL inorder_req_%0d got=%h exp=%h", j, (reqLog.size() > j) ? reqLog[j] : 32'hxxxx_xxxx, j * 4);
      end
    end
  endtask

  task automatic test_stall();
    memLat = 1;
    doReset();
    #3;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        checks++; if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'h0 || ifc.inst_data !== 32'h0) begin
          failures++; $display("[TB] FAIL stall_head_c%0d got v=%b pc=%h data=%h exp v=1 pc=0 data=0", i, ifc.inst_valid, ifc.inst_pc, ifc.inst_data);
        end
      end
      if (i < 9) begin @(negedge clk); #3; end
    end
    checks++; if (ifc.dbg_count !== 3'd4) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=4", ifc.dbg_count); end
    checks++; if (ifc.mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_valid got=%b exp=0", ifc.mem_req_valid); end
  endtask

  task automatic test_redirect();
    int k = 0;
    logic [31:0] expPc [2];
    logic [31:0] expData [2];
    expPc[0] = 32'h100; expPc[1] = 32'h104;
    expData[0] = 32'h40; expData[1] = 32'h41;
    memLat = 4;
    doReset();
    ifc.inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h100;
    #3;
    checks++; if (ifc.mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL redir_no_req got=%b exp=0", ifc.mem_req_valid); end
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #3;
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h100) begin
      failures++; $display("[TB] FAIL redir_req got valid=%b addr=%h exp valid=1 addr=100", ifc.mem_req_valid, ifc.mem_req_addr);
    end
    for (int i = 0; i < 20 && k < 2; i++) begin
      if (ifc.inst_valid) begin
        checks++; if (ifc.inst_pc !== expPc[k] || ifc.inst_data !== expData[k]) begin
          failures++; $display("[TB] FAIL redir_inst_%0d got pc=%h data=%h exp pc=%h data=%h", k, ifc.inst_pc, ifc.inst_data, expPc[k], expData[k]);
        end
        k++;
      end
      @(negedge clk); #3;
    end
    checks++; if (k != 2) begin failures++; $display("[TB] FAIL redir_timeout got=%0d exp=2", k); end
  endtask

  task automatic test_redirect_align();
    bit seen = 1'b0;
    memLat = 1;
    doReset();
    ifc.inst_ready = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h203;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #3;
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h200) begin
      failures++; $display("[TB] FAIL align_req got valid=%b addr=%h exp valid=1 addr=200", ifc.mem_req_valid, ifc.mem_req_addr);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ifc.inst_valid) begin
        seen = 1'b1;
        checks++; if (i != 2 || ifc.inst_pc !== 32'h200 || ifc.inst_data !== 32'h80) begin
          failures++; $display("[TB] FAIL align_inst got cyc=%0d pc=%h data=%h exp cyc=2 pc=200 data=80", i, ifc.inst_pc, ifc.inst_data);
        end
      end
      @(negedge clk); #3;
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL align_timeout got=0 exp=1"); end
  endtask

  task automatic test_redirect_pop_rsp();
    int k = 0;
    memLat = 1;
    doReset();
    ifc.inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h300;
    #3;
    checks++; if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'h4) begin
      failures++; $display("[TB] FAIL rpr_head got v=%b pc=%h exp v=1 pc=4", ifc.inst_valid, ifc.inst_pc);
    end
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #3;
    checks++; if (ifc.inst_valid !== 1'b0 || ifc.dbg_count !== 3'd0) begin
      failures++; $display("[TB] FAIL rpr_flush got v=%b count=%0d exp v=0 count=0", ifc.inst_valid, ifc.dbg_count);
    end
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h300) begin
      failures++; $display("[TB] FAIL rpr_req got valid=%b addr=%h exp valid=1 addr=300", ifc.mem_req_valid, ifc.mem_req_addr);
    end
    for (int i = 0; i < 16 && k < 2; i++) begin
      if (ifc.inst_valid) begin
        checks++; if (ifc.inst_pc !== 32'(32'h300 + k * 4) || ifc.inst_data !== 32'(32'hC0 + k)) begin
          failures++; $display("[TB] FAIL rpr_inst_%0d got pc=%h data=%h exp pc=%h data=%h", k, ifc.inst_pc, ifc.inst_data, 32'h300 + k * 4, 32'hC0 + k);
        end
        k++;
      end
      @(negedge clk); #3;
    end
    checks++; if (k != 2) begin failures++; $display("[TB] FAIL rpr_timeout got=%0d exp=2", k); end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    memLat = 3;
    doReset();
    ifc.inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    #3;
    checks++; if (ifc.mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_req_in_reset got=%b exp=0", ifc.mem_req_valid); end
    @(negedge clk);
    nreset = 1'b0;
    memReady = 1'b0;
    reqLog.delete();
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++; if (ifc.inst_valid !== 1'b0 || ifc.dbg_count !== 3'd0) begin
        failures++; $display("[TB] FAIL mid_late_rsp_%0d got v=%b count=%0d exp v=0 count=0", i, ifc.inst_valid, ifc.dbg_count);
      end
      @(negedge clk);
    end
    memReady = 1'b1;
    #3;
    checks++; if (ifc.inst_valid !== 1'b0 || ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h0) begin
      failures++; $display("[TB] FAIL mid_first_req got iv=%b rv=%b addr=%h exp iv=0 rv=1 addr=0", ifc.inst_valid, ifc.mem_req_valid, ifc.mem_req_addr);
    end
    for (int i = 0; i < 12 && !seen; i++) begin
      if (ifc.inst_valid) begin
        seen = 1'b1;
        checks++; if (i != 4 || ifc.inst_pc !== 32'h0 || ifc.inst_data !== 32'h0) begin
          failures++; $display("[TB] FAIL mid_inst got cyc=%0d pc=%h data=%h exp cyc=4 pc=0 data=0", i, ifc.inst_pc, ifc.inst_data);
        end
      end
      @(negedge clk); #3;
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL mid_timeout got=0 exp=1"); end
  endtask

  initial begin
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    ifc.inst_ready = 1'b0;
    test_reset();
    test_in_order();
    test_stall();
    test_redirect();
    test_redirect_align();
    test_redirect_pop_rsp();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
